// File: rtl/buckeye_shift_engine.sv
// Serial configuration shift engine for NCHIP Buckeye chains: shifts a parallel image
// out LSB-first, captures the displaced bits as readback, and optionally verifies.
module buckeye_shift_engine #(
    parameter int NCHIP     = 6,
    parameter int CHIP_BITS = 48,
    parameter int CLK_DIV   = 4
) (
    input  logic                         CMSCLK,
    input  logic                         GLOBAL_RST_B,
    input  logic                         START,
    input  logic                         ABORT,
    input  logic                         VERIFY,
    input  logic [NCHIP-1:0]             MASK,
    input  logic [NCHIP*CHIP_BITS-1:0]   WDATA,
    input  logic [NCHIP-1:0]             AMPOUT,
    output logic [NCHIP-1:0]             AMPIN,
    output logic [NCHIP-1:0]             AMPCLK,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [NCHIP*CHIP_BITS-1:0]   RDATA,
    output logic [NCHIP-1:0]             ERR
);

    localparam int PW = $clog2(2 * CLK_DIV);
    localparam int BW = $clog2(CHIP_BITS);
    localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PH_HIGH = PW'(CLK_DIV);
    localparam logic [PW-1:0] PH_CAP  = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(CHIP_BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT1, S_SHIFT2, S_FIN} state_t;

    state_t state, state_nx;
    logic [PW-1:0] phase, phase_nx;
    logic [BW-1:0] bit_idx, bit_nx;
    logic [NCHIP-1:0][CHIP_BITS-1:0] img, img_nx, rd, rd_nx;
    logic [NCHIP-1:0] mask_q, mask_nx, ampin_nx, ampclk_nx, err_nx;
    logic verify_q, verify_nx, busy_nx, done_nx;

    assign RDATA = rd;

    always_comb begin
        state_nx  = state;
        phase_nx  = phase;
        bit_nx    = bit_idx;
        img_nx    = img;
        mask_nx   = mask_q;
        verify_nx = verify_q;
        rd_nx     = rd;
        err_nx    = ERR;
        busy_nx   = 1'b0;
        done_nx   = 1'b0;
        ampin_nx  = '0;
        ampclk_nx = '0;

        if (state != S_IDLE && ABORT) begin
            state_nx = S_IDLE;
            phase_nx = '0;
            bit_nx   = '0;
            err_nx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START && !ABORT) begin
                        img_nx    = WDATA;
                        mask_nx   = MASK;
                        verify_nx = VERIFY;
                        err_nx    = '0;
                        phase_nx  = '0;
                        bit_nx    = '0;
                        state_nx  = S_SHIFT1;
                    end
                end
                S_SHIFT1, S_SHIFT2: begin
                    // Sample the chain on the edge that raises AMPCLK, before it shifts.
                    if (phase == PH_CAP) begin
                        for (int unsigned k = 0; k < NCHIP; k++) begin
                            if (mask_q[k]) rd_nx[k][bit_idx] = AMPOUT[k];
                        end
                    end
                    if (phase == PH_LAST) begin
                        phase_nx = '0;
                        if (bit_idx == BIT_LAST) begin
                            bit_nx = '0;
                            if (state == S_SHIFT1 && verify_q) begin
                                state_nx = S_SHIFT2;
                            end else begin
                                state_nx = S_FIN;
                                if (state == S_SHIFT2) begin
                                    for (int unsigned k = 0; k < NCHIP; k++) begin
                                        err_nx[k] = mask_q[k] && (rd[k] != img[k]);
                                    end
                                end
                            end
                        end else begin
                            bit_nx = bit_idx + BW'(1);
                        end
                    end else begin
                        phase_nx = phase + PW'(1);
                    end
                end
                S_FIN:   state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end

        // Pin outputs are computed from the next state so each one is a plain flop.
        if (state_nx == S_SHIFT1 || state_nx == S_SHIFT2) begin
            busy_nx = 1'b1;
            for (int unsigned k = 0; k < NCHIP; k++) begin
                ampin_nx[k]  = mask_nx[k] & img_nx[k][bit_nx];
                ampclk_nx[k] = mask_nx[k] & (phase_nx >= PH_HIGH);
            end
        end
        done_nx = (state_nx == S_FIN);
    end

    always_ff @(posedge CMSCLK or negedge GLOBAL_RST_B) begin
        if (!GLOBAL_RST_B) begin
            state    <= S_IDLE;
            phase    <= '0;
            bit_idx  <= '0;
            img      <= '0;
            mask_q   <= '0;
            verify_q <= 1'b0;
            rd       <= '0;
            ERR      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            AMPIN    <= '0;
            AMPCLK   <= '0;
        end else begin
            state    <= state_nx;
            phase    <= phase_nx;
            bit_idx  <= bit_nx;
            img      <= img_nx;
            mask_q   <= mask_nx;
            verify_q <= verify_nx;
            rd       <= rd_nx;
            ERR      <= err_nx;
            BUSY     <= busy_nx;
            DONE     <= done_nx;
            AMPIN    <= ampin_nx;
            AMPCLK   <= ampclk_nx;
        end
    end

endmodule
